// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: carries the EX result bundle into MEM and
// returns the multi-cycle MADD/MSUB partial HI/LO and step count to EX.
module ex_mem_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned ALUOP_W = 8,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned EX_IDX  = 3,
  parameter int unsigned MEM_IDX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic [RADDR_W-1:0]   ex_wd,
  input  logic                 ex_wreg,
  input  logic [DATA_W-1:0]    ex_wdata,
  input  logic                 ex_whilo,
  input  logic [DATA_W-1:0]    ex_hi,
  input  logic [DATA_W-1:0]    ex_lo,
  input  logic [ALUOP_W-1:0]   ex_aluop,
  input  logic [DATA_W-1:0]    ex_mem_addr,
  input  logic [DATA_W-1:0]    ex_reg2,
  input  logic                 ex_valid,
  input  logic [2*DATA_W-1:0]  hilo_i,
  input  logic [CNT_W-1:0]     cnt_i,
  output logic [RADDR_W-1:0]   mem_wd,
  output logic                 mem_wreg,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_whilo,
  output logic [DATA_W-1:0]    mem_hi,
  output logic [DATA_W-1:0]    mem_lo,
  output logic [ALUOP_W-1:0]   mem_aluop,
  output logic [DATA_W-1:0]    mem_mem_addr,
  output logic [DATA_W-1:0]    mem_reg2,
  output logic                 mem_valid,
  output logic [2*DATA_W-1:0]  hilo_o,
  output logic [CNT_W-1:0]     cnt_o
);

  typedef struct packed {
    logic [RADDR_W-1:0] wd;
    logic               wreg;
    logic [DATA_W-1:0]  wdata;
    logic               whilo;
    logic [DATA_W-1:0]  hi;
    logic [DATA_W-1:0]  lo;
    logic [ALUOP_W-1:0] aluop;
    logic [DATA_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  reg2;
    logic               valid;
  } bundle_t;

  // Per-edge update action; reset is handled directly in the register block.
  typedef enum logic [1:0] {
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_ADVANCE
  } act_e;

  act_e                act;
  bundle_t             ex_bundle;
  bundle_t             bundle_q, bundle_d;
  logic [2*DATA_W-1:0] hilo_q, hilo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  assign ex_bundle = '{
    wd:       ex_wd,
    wreg:     ex_wreg,
    wdata:    ex_wdata,
    whilo:    ex_whilo,
    hi:       ex_hi,
    lo:       ex_lo,
    aluop:    ex_aluop,
    mem_addr: ex_mem_addr,
    reg2:     ex_reg2,
    valid:    ex_valid
  };

  // Resolve flush > MEM hold > EX bubble > advance.
  always_comb begin
    act = ACT_ADVANCE;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (stall[MEM_IDX]) begin
      act = ACT_HOLD;
    end else if (stall[EX_IDX]) begin
      act = ACT_BUBBLE;
    end
  end

  // Next-state selection for the bundle and the multi-cycle side state.
  always_comb begin
    bundle_d = bundle_q;
    hilo_d   = hilo_q;
    cnt_d    = cnt_q;
    unique case (act)
      ACT_FLUSH: begin
        bundle_d = '0;
        hilo_d   = '0;
        cnt_d    = '0;
      end
      ACT_HOLD: begin
        bundle_d = bundle_q;
        hilo_d   = hilo_q;
        cnt_d    = cnt_q;
      end
      // MEM gets a NOP while EX's accumulate state is parked here for one cycle.
      ACT_BUBBLE: begin
        bundle_d = '0;
        hilo_d   = hilo_i;
        cnt_d    = cnt_i;
      end
      ACT_ADVANCE: begin
        bundle_d = ex_bundle;
        hilo_d   = '0;
        cnt_d    = '0;
      end
      default: begin
        bundle_d = '0;
        hilo_d   = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bundle_q <= '0;
      hilo_q   <= '0;
      cnt_q    <= '0;
    end else begin
      bundle_q <= bundle_d;
      hilo_q   <= hilo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_wd       = bundle_q.wd;
  assign mem_wreg     = bundle_q.wreg;
  assign mem_wdata    = bundle_q.wdata;
  assign mem_whilo    = bundle_q.whilo;
  assign mem_hi       = bundle_q.hi;
  assign mem_lo       = bundle_q.lo;
  assign mem_aluop    = bundle_q.aluop;
  assign mem_mem_addr = bundle_q.mem_addr;
  assign mem_reg2     = bundle_q.reg2;
  assign mem_valid    = bundle_q.valid;
  assign hilo_o       = hilo_q;
  assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: a vector table for the default-width
// instance plus a short hand sequence for a 64-bit-data instance.
module tb_ex_mem_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance signals
  logic        rst, flush;
  logic [5:0]  stall;
  logic [4:0]  ex_wd;
  logic        ex_wreg, ex_whilo, ex_valid;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo, mem_valid;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  // Wide instance signals (DATA_W=64, RADDR_W=6)
  logic         w_rst, w_flush;
  logic [5:0]   w_stall;
  logic [5:0]   w_ex_wd, w_mem_wd;
  logic         w_ex_wreg, w_ex_whilo, w_ex_valid;
  logic         w_mem_wreg, w_mem_whilo, w_mem_valid;
  logic [63:0]  w_ex_wdata, w_ex_hi, w_ex_lo, w_ex_mem_addr, w_ex_reg2;
  logic [63:0]  w_mem_wdata, w_mem_hi, w_mem_lo, w_mem_mem_addr, w_mem_reg2;
  logic [7:0]   w_ex_aluop, w_mem_aluop;
  logic [127:0] w_hilo_i, w_hilo_o;
  logic [1:0]   w_cnt_i, w_cnt_o;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .ex_valid(ex_valid), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .mem_valid(mem_valid), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  ex_mem_pipe #(.DATA_W(64), .RADDR_W(6)) dut_w (
    .clk(clk), .rst(w_rst), .stall(w_stall), .flush(w_flush),
    .ex_wd(w_ex_wd), .ex_wreg(w_ex_wreg), .ex_wdata(w_ex_wdata),
    .ex_whilo(w_ex_whilo), .ex_hi(w_ex_hi), .ex_lo(w_ex_lo),
    .ex_aluop(w_ex_aluop), .ex_mem_addr(w_ex_mem_addr), .ex_reg2(w_ex_reg2),
    .ex_valid(w_ex_valid), .hilo_i(w_hilo_i), .cnt_i(w_cnt_i),
    .mem_wd(w_mem_wd), .mem_wreg(w_mem_wreg), .mem_wdata(w_mem_wdata),
    .mem_whilo(w_mem_whilo), .mem_hi(w_mem_hi), .mem_lo(w_mem_lo),
    .mem_aluop(w_mem_aluop), .mem_mem_addr(w_mem_mem_addr), .mem_reg2(w_mem_reg2),
    .mem_valid(w_mem_valid), .hilo_o(w_hilo_o), .cnt_o(w_cnt_o)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [7:0]  aluop;
    logic        valid;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [7:0]  e_aluop;
    logic        e_valid;
    logic        e_side;   // 1: hi/lo/addr/reg2 carry values derived from e_wdata; 0: zero
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Side fields are tied to wdata so every vector exercises distinct patterns.
  function automatic logic [31:0] f_hi(input logic [31:0] w);   return w ^ 32'hFFFF_0000; endfunction
  function automatic logic [31:0] f_lo(input logic [31:0] w);   return w + 32'd7; endfunction
  function automatic logic [31:0] f_addr(input logic [31:0] w); return {w[29:0], 2'b00}; endfunction
  function automatic logic [31:0] f_reg2(input logic [31:0] w); return w ^ 32'h5A5A_5A5A; endfunction

  function automatic vec_t mk(
    input logic r, input logic fl, input logic [5:0] st,
    input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
    input logic whilo, input logic [7:0] aluop, input logic valid,
    input logic [63:0] hi_i, input logic [1:0] c_i,
    input logic [4:0] ewd, input logic ewreg, input logic [31:0] ewdata,
    input logic ewhilo, input logic [7:0] ealuop, input logic evalid,
    input logic eside, input logic [63:0] ehilo, input logic [1:0] ecnt);
    vec_t v;
    v.rst = r; v.flush = fl; v.stall = st;
    v.wd = wd; v.wreg = wreg; v.wdata = wdata; v.whilo = whilo;
    v.aluop = aluop; v.valid = valid; v.hilo_i = hi_i; v.cnt_i = c_i;
    v.e_wd = ewd; v.e_wreg = ewreg; v.e_wdata = ewdata; v.e_whilo = ewhilo;
    v.e_aluop = ealuop; v.e_valid = evalid; v.e_side = eside;
    v.e_hilo = ehilo; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; flush = v.flush; stall = v.stall;
    ex_wd = v.wd; ex_wreg = v.wreg; ex_wdata = v.wdata; ex_whilo = v.whilo;
    ex_hi = f_hi(v.wdata); ex_lo = f_lo(v.wdata);
    ex_mem_addr = f_addr(v.wdata); ex_reg2 = f_reg2(v.wdata);
    ex_aluop = v.aluop; ex_valid = v.valid; hilo_i = v.hilo_i; cnt_i = v.cnt_i;
  endtask

  task automatic compare(input vec_t v, input int idx);
    check("mem_wd",       idx, 128'(mem_wd),       128'(v.e_wd));
    check("mem_wreg",     idx, 128'(mem_wreg),     128'(v.e_wreg));
    check("mem_wdata",    idx, 128'(mem_wdata),    128'(v.e_wdata));
    check("mem_whilo",    idx, 128'(mem_whilo),    128'(v.e_whilo));
    check("mem_hi",       idx, 128'(mem_hi),       128'(v.e_side ? f_hi(v.e_wdata)   : 32'h0));
    check("mem_lo",       idx, 128'(mem_lo),       128'(v.e_side ? f_lo(v.e_wdata)   : 32'h0));
    check("mem_aluop",    idx, 128'(mem_aluop),    128'(v.e_aluop));
    check("mem_mem_addr", idx, 128'(mem_mem_addr), 128'(v.e_side ? f_addr(v.e_wdata) : 32'h0));
    check("mem_reg2",     idx, 128'(mem_reg2),     128'(v.e_side ? f_reg2(v.e_wdata) : 32'h0));
    check("mem_valid",    idx, 128'(mem_valid),    128'(v.e_valid));
    check("hilo_o",       idx, 128'(hilo_o),       128'(v.e_hilo));
    check("cnt_o",        idx, 128'(cnt_o),        128'(v.e_cnt));
  endtask

  initial begin
    // Wide instance parked in reset while the table runs
    w_rst = 1'b0; w_flush = 1'b0; w_stall = '0;
    w_ex_wd = '0; w_ex_wreg = 1'b0; w_ex_wdata = '0; w_ex_whilo = 1'b0;
    w_ex_hi = '0; w_ex_lo = '0; w_ex_aluop = '0; w_ex_mem_addr = '0;
    w_ex_reg2 = '0; w_ex_valid = 1'b0; w_hilo_i = '0; w_cnt_i = '0;

    // rst flush stall    wd wreg wdata          whilo aluop  valid hilo_i                 cnt | ewd ewreg ewdata        ewhilo ealuop evalid side ehilo                  ecnt
    tbl.push_back(mk(0, 0, 6'b000000, 5'd7,  1, 32'hDEADBEEF, 1, 8'h21, 1, 64'h55,                 2'd3, 5'd0,  0, 32'h0,        0, 8'h00, 0, 0, 64'h0,                  2'd0));
    tbl.push_back(mk(0, 0, 6'b000000, 5'd7,  1, 32'hDEADBEEF, 1, 8'h21, 1, 64'h55,                 2'd3, 5'd0,  0, 32'h0,        0, 8'h00, 0, 0, 64'h0,                  2'd0));
    tbl.push_back(mk(1, 0, 6'b000000, 5'd7,  1, 32'hDEADBEEF, 1, 8'h21, 1, 64'h55,                 2'd3, 5'd7,  1, 32'hDEADBEEF, 1, 8'h21, 1, 1, 64'h0,                  2'd0));
    // stream of four bundles
    tbl.push_back(mk(1, 0, 6'b000000, 5'd1,  1, 32'd1,        1, 8'h11, 1, 64'h0,                  2'd0, 5'd1,  1, 32'd1,        1, 8'h11, 1, 1, 64'h0,                  2'd0));
    tbl.push_back(mk(1, 0, 6'b000000, 5'd2,  1, 32'd2,        0, 8'h12, 1, 64'h0,                  2'd0, 5'd2,  1, 32'd2,        0, 8'h12, 1, 1, 64'h0,                  2'd0));
    tbl.push_back(mk(1, 0, 6'b000000, 5'd3,  1, 32'd3,        1, 8'h13, 1, 64'h0,                  2'd0, 5'd3,  1, 32'd3,        1, 8'h13, 1, 1, 64'h0,                  2'd0));
    tbl.push_back(mk(1, 0, 6'b000000, 5'd4,  1, 32'd4,        0, 8'h14, 1, 64'h0,                  2'd0, 5'd4,  1, 32'd4,        0, 8'h14, 1, 1, 64'h0,                  2'd0));
    // bubble with accumulate, then advance
    tbl.push_back(mk(1, 0, 6'b001111, 5'd9,  1, 32'h99,       1, 8'h24, 1, 64'h0000_0001_0000_0002, 2'd1, 5'd0,  0, 32'h0,        0, 8'h00, 0, 0, 64'h0000_0001_0000_0002, 2'd1));
    tbl.push_back(mk(1, 0, 6'b000000, 5'd11, 1, 32'h77,       1, 8'h24, 1, 64'hFFFF,               2'd2, 5'd11, 1, 32'h77,       1, 8'h24, 1, 1, 64'h0,                  2'd0));
    // bubble then hold keeps partial result
    tbl.push_back(mk(1, 0, 6'b001111, 5'd12, 1, 32'h88,       1, 8'h25, 1, 64'hCAFE_0000_0000_BEEF, 2'd2, 5'd0,  0, 32'h0,        0, 8'h00, 0, 0, 64'hCAFE_0000_0000_BEEF, 2'd2));
    tbl.push_back(mk(1, 0, 6'b011111, 5'd13, 1, 32'h66,       1, 8'h26, 1, 64'h1234,               2'd3, 5'd0,  0, 32'h0,        0, 8'h00, 0, 0, 64'hCAFE_0000_0000_BEEF, 2'd2));
    // load A5A5A5A5 then hold three cycles with changing EX inputs
    tbl.push_back(mk(1, 0, 6'b000000, 5'd3,  1, 32'hA5A5A5A5, 0, 8'h2B, 1, 64'h0,                  2'd0, 5'd3,  1, 32'hA5A5A5A5, 0, 8'h2B, 1, 1, 64'h0,                  2'd0));
    tbl.push_back(mk(1, 0, 6'b011111, 5'd20, 0, 32'hB0,       1, 8'h00, 0, 64'h1111,               2'd3, 5'd3,  1, 32'hA5A5A5A5, 0, 8'h2B, 1, 1, 64'h0,                  2'd0));
    tbl.push_back(mk(1, 0, 6'b011111, 5'd21, 1, 32'hB1,       0, 8'h01, 1, 64'h2222,               2'd1, 5'd3,  1, 32'hA5A5A5A5, 0, 8'h2B, 1, 1, 64'h0,                  2'd0));
    tbl.push_back(mk(1, 0, 6'b011111, 5'd22, 0, 32'hB2,       1, 8'h02, 0, 64'h3333,               2'd2, 5'd3,  1, 32'hA5A5A5A5, 0, 8'h2B, 1, 1, 64'h0,                  2'd0));
    // flush beats hold
    tbl.push_back(mk(1, 1, 6'b011111, 5'd5,  1, 32'h42,       1, 8'h2B, 1, 64'h9,                  2'd1, 5'd0,  0, 32'h0,        0, 8'h00, 0, 0, 64'h0,                  2'd0));
    // MEM-only stall holds and drops EX data
    tbl.push_back(mk(1, 0, 6'b000000, 5'd4,  1, 32'h1234,     1, 8'h23, 1, 64'h0,                  2'd0, 5'd4,  1, 32'h1234,     1, 8'h23, 1, 1, 64'h0,                  2'd0));
    tbl.push_back(mk(1, 0, 6'b010000, 5'd6,  0, 32'h5678,     0, 8'h30, 0, 64'h44,                 2'd1, 5'd4,  1, 32'h1234,     1, 8'h23, 1, 1, 64'h0,                  2'd0));
    // EX-only stall bit is a bubble
    tbl.push_back(mk(1, 0, 6'b001000, 5'd8,  1, 32'h9ABC,     1, 8'h31, 1, 64'h7,                  2'd3, 5'd0,  0, 32'h0,        0, 8'h00, 0, 0, 64'h7,                  2'd3));
    // reset during stall, released while still stalled
    tbl.push_back(mk(0, 0, 6'b011111, 5'd8,  1, 32'h9ABC,     1, 8'h31, 1, 64'h7,                  2'd3, 5'd0,  0, 32'h0,        0, 8'h00, 0, 0, 64'h0,                  2'd0));
    tbl.push_back(mk(1, 0, 6'b011111, 5'd8,  1, 32'h9ABC,     1, 8'h31, 1, 64'h7,                  2'd3, 5'd0,  0, 32'h0,        0, 8'h00, 0, 0, 64'h0,                  2'd0));
    // flush beats advance and bubble
    tbl.push_back(mk(1, 0, 6'b000000, 5'd30, 1, 32'hFACE,     1, 8'h40, 1, 64'h0,                  2'd0, 5'd30, 1, 32'hFACE,     1, 8'h40, 1, 1, 64'h0,                  2'd0));
    tbl.push_back(mk(1, 1, 6'b000000, 5'd30, 1, 32'hFACE,     1, 8'h40, 1, 64'h0,                  2'd0, 5'd0,  0, 32'h0,        0, 8'h00, 0, 0, 64'h0,                  2'd0));
    tbl.push_back(mk(1, 1, 6'b001000, 5'd2,  1, 32'h10,       1, 8'h41, 1, 64'h5,                  2'd2, 5'd0,  0, 32'h0,        0, 8'h00, 0, 0, 64'h0,                  2'd0));
    // all-ones bundle
    tbl.push_back(mk(1, 0, 6'b000000, 5'd31, 1, 32'hFFFFFFFF, 1, 8'hFF, 1, 64'h0,                  2'd0, 5'd31, 1, 32'hFFFFFFFF, 1, 8'hFF, 1, 1, 64'h0,                  2'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i]);
      @(posedge clk);
      #1;
      compare(tbl[i], i);
    end

    // Wide instance: reset, 64-bit pass-through, 128-bit partial in bubble
    @(negedge clk);
    w_rst = 1'b0;
    w_ex_wd = 6'd45; w_ex_wreg = 1'b1; w_ex_wdata = 64'h0123_4567_89AB_CDEF; w_ex_valid = 1'b1;
    @(posedge clk); #1;
    check("w_reset_wdata", 0, 128'(w_mem_wdata), 128'h0);
    check("w_reset_valid", 0, 128'(w_mem_valid), 128'h0);
    @(negedge clk);
    w_rst = 1'b1;
    @(posedge clk); #1;
    check("w_mem_wdata", 1, 128'(w_mem_wdata), 128'(64'h0123_4567_89AB_CDEF));
    check("w_mem_wd",    1, 128'(w_mem_wd),    128'(6'd45));
    check("w_mem_wreg",  1, 128'(w_mem_wreg),  128'h1);
    @(negedge clk);
    w_stall = 6'b001111;
    w_hilo_i = 128'hFEDC_BA98_7654_3210_0011_2233_4455_6677;
    w_cnt_i = 2'd2;
    @(posedge clk); #1;
    check("w_hilo_o",    2, w_hilo_o,          128'hFEDC_BA98_7654_3210_0011_2233_4455_6677);
    check("w_cnt_o",     2, 128'(w_cnt_o),     128'(2'd2));
    check("w_mem_wreg",  2, 128'(w_mem_wreg),  128'h0);
    check("w_mem_wdata", 2, 128'(w_mem_wdata), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
